// File: rtl/hazard_pkg.sv
// Shared constants and FSM encoding for the pipeline hazard controller.
// Forwarding select codes match the EXE-stage operand mux ordering.
package hazard_pkg;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_EXEMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB  = 2'b10;

    localparam int MD_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LDSTALL = 2'd1,
        MDBUSY  = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of hazard_ctrl; master = pipeline, slave = hazard_ctrl.
// HAZARD_STATS_EN adds the stall_count / md_count statistics outputs.
interface hazard_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs_ID;
    logic [ADDR_W-1:0] rt_ID;
    logic              usesRt_ID;
    logic [ADDR_W-1:0] rs_EXE;
    logic [ADDR_W-1:0] rt_EXE;
    logic [ADDR_W-1:0] regWriteAddress_EXEtoMEM;
    logic [ADDR_W-1:0] regWriteAddress_MEMtoWB;
    logic              regShouldWrite_EXEtoMEM;
    logic              regShouldWrite_MEMtoWB;
    logic              isRtype_EXEtoMEM;
    logic              isRtype_MEMtoWB;
    logic              memRead_IDtoEXE;
    logic [ADDR_W-1:0] regWriteAddress_IDtoEXE;
    logic              mdStart_ID;
    logic              hiloRead_ID;
    logic [1:0]        fwdA_sel;
    logic [1:0]        fwdB_sel;
    logic              stall_IF;
    logic              stall_ID;
    logic              flush_EXE;
    logic              md_go;
    logic              md_busy;
    logic              md_done;
`ifdef HAZARD_STATS_EN
    logic [31:0]       stall_count;
    logic [15:0]       md_count;
`endif

    modport master (
        output rs_ID, rt_ID, usesRt_ID, rs_EXE, rt_EXE,
               regWriteAddress_EXEtoMEM, regWriteAddress_MEMtoWB,
               regShouldWrite_EXEtoMEM, regShouldWrite_MEMtoWB,
               isRtype_EXEtoMEM, isRtype_MEMtoWB,
               memRead_IDtoEXE, regWriteAddress_IDtoEXE,
               mdStart_ID, hiloRead_ID,
        input  fwdA_sel, fwdB_sel, stall_IF, stall_ID, flush_EXE,
               md_go, md_busy, md_done
`ifdef HAZARD_STATS_EN
        , input stall_count, md_count
`endif
    );

    modport slave (
        input  rs_ID, rt_ID, usesRt_ID, rs_EXE, rt_EXE,
               regWriteAddress_EXEtoMEM, regWriteAddress_MEMtoWB,
               regShouldWrite_EXEtoMEM, regShouldWrite_MEMtoWB,
               isRtype_EXEtoMEM, isRtype_MEMtoWB,
               memRead_IDtoEXE, regWriteAddress_IDtoEXE,
               mdStart_ID, hiloRead_ID,
        output fwdA_sel, fwdB_sel, stall_IF, stall_ID, flush_EXE,
               md_go, md_busy, md_done
`ifdef HAZARD_STATS_EN
        , output stall_count, md_count
`endif
    );

endinterface

// File: rtl/hazard_ctrl_md_sequencer.sv
// Hazard FSM plus fixed-latency mult/div sequencer: accepts starts, counts down, pulses done.
// md_go is same-cycle with the accepted start; md_busy/md_done are registered.
module md_sequencer
    import hazard_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = 6
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      lu,
    input  logic      md_start,
    output logic      md_go,
    output logic      md_busy,
    output logic      md_done,
    output hz_state_e state
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_go   = 1'b0;
        case (state_q)
            IDLE: begin
                // A load-use hazard outranks a start; the start retries after the bubble.
                if (lu) begin
                    state_d = LDSTALL;
                end else if (md_start) begin
                    md_go   = 1'b1;
                    state_d = MDBUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            LDSTALL: begin
                if (md_start && !lu) begin
                    md_go   = 1'b1;
                    state_d = MDBUSY;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            MDBUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == MDBUSY);
        done_d = (state_d == MDBUSY) && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign md_busy = busy_q;
    assign md_done = done_q;
    assign state   = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: EXE operand forwarding, load-use bubble, mult/div stall merging.
// Forwarding and stalls are combinational; HAZARD_STATS_EN adds saturating stall/md counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = 6
) (
    input  logic          CLK,
    input  logic          RST,
    hazard_ctrl_if.slave  hz
);

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    logic      em_wr;
    logic      mw_wr;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic      lu;
    logic      stall;
    logic      md_go;
    logic      md_busy;
    logic      md_done;
    hz_state_e state;

    // Register 0 is hardwired, so writes to it are never forwarded.
    assign em_wr = hz.regShouldWrite_EXEtoMEM && (hz.regWriteAddress_EXEtoMEM != REG_ZERO);
    assign mw_wr = hz.regShouldWrite_MEMtoWB  && (hz.regWriteAddress_MEMtoWB  != REG_ZERO);

    always_comb begin
        fwd_a = FWD_RF;
        if (em_wr && (hz.regWriteAddress_EXEtoMEM == hz.rs_EXE)) begin
            fwd_a = FWD_EXEMEM;
        end else if (mw_wr && (hz.regWriteAddress_MEMtoWB == hz.rs_EXE)) begin
            fwd_a = FWD_MEMWB;
        end

        fwd_b = FWD_RF;
        if (em_wr && hz.isRtype_EXEtoMEM && (hz.regWriteAddress_EXEtoMEM == hz.rt_EXE)) begin
            fwd_b = FWD_EXEMEM;
        end else if (mw_wr && hz.isRtype_MEMtoWB && (hz.regWriteAddress_MEMtoWB == hz.rt_EXE)) begin
            fwd_b = FWD_MEMWB;
        end
    end

    assign lu = hz.memRead_IDtoEXE && (hz.regWriteAddress_IDtoEXE != REG_ZERO) &&
                ((hz.regWriteAddress_IDtoEXE == hz.rs_ID) ||
                 (hz.usesRt_ID && (hz.regWriteAddress_IDtoEXE == hz.rt_ID)));

    md_sequencer #(
        .MD_CYCLES (MD_CYCLES),
        .CNT_W     (CNT_W)
    ) u_md_seq (
        .clk      (CLK),
        .rst      (RST),
        .lu       (lu),
        .md_start (hz.mdStart_ID),
        .md_go    (md_go),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .state    (state)
    );

    // Load-use bubbles only from IDLE; HI/LO consumers and new starts wait out MDBUSY.
    assign stall = ((state == IDLE) && lu) ||
                   (md_busy && (hz.hiloRead_ID || hz.mdStart_ID));

    assign hz.fwdA_sel  = fwd_a;
    assign hz.fwdB_sel  = fwd_b;
    assign hz.stall_IF  = stall;
    assign hz.stall_ID  = stall;
    assign hz.flush_EXE = stall;
    assign hz.md_go     = md_go;
    assign hz.md_busy   = md_busy;
    assign hz.md_done   = md_done;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [15:0] md_count_q, md_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        md_count_d    = md_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
        if (md_go && (md_count_q != '1)) begin
            md_count_d = md_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_count_q <= '0;
            md_count_q    <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            md_count_q    <= md_count_d;
        end
    end

    assign hz.stall_count = stall_count_q;
    assign hz.md_count    = md_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (MD_CYCLES=4): directed scenarios plus randomized traffic
// against a cycle-number based reference model.
module tb_hazard_ctrl;

    localparam int MD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.ADDR_W(5)) hif ();

    hazard_ctrl #(.ADDR_W(5), .MD_CYCLES(MD), .CNT_W(6)) dut (
        .CLK (clk),
        .RST (rst),
        .hz  (hif.slave)
    );

    int vec = 0;
    int err = 0;

    // Reference model: cycle index of the last accepted start and of the last load-use bubble.
    int n   = 0;
    int t0  = -1000;
    int tlu = -1000;
    logic        m_busy, m_done, m_stall, m_go, m_lu, m_idle;
    logic [1:0]  m_fa, m_fb;
    logic [31:0] m_sc = '0;
    logic [15:0] m_mc = '0;

    function automatic logic [1:0] fwd_ref(input logic [4:0] src,
                                           input logic [4:0] a1, input logic w1, input logic g1,
                                           input logic [4:0] a2, input logic w2, input logic g2);
        if (w1 && g1 && a1 != 5'd0 && a1 == src) return 2'b01;
        if (w2 && g2 && a2 != 5'd0 && a2 == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [5:0] ctl();
        return {hif.stall_IF, hif.stall_ID, hif.flush_EXE, hif.md_go, hif.md_busy, hif.md_done};
    endfunction

    task automatic model_eval();
        m_busy = (n > t0) && (n <= t0 + MD);
        m_done = m_busy && (n == t0 + MD);
        m_idle = !m_busy && (n != tlu + 1);
        m_lu   = hif.memRead_IDtoEXE && hif.regWriteAddress_IDtoEXE != 5'd0 &&
                 (hif.regWriteAddress_IDtoEXE == hif.rs_ID ||
                  (hif.usesRt_ID && hif.regWriteAddress_IDtoEXE == hif.rt_ID));
        m_stall = (m_idle && m_lu) || (m_busy && (hif.hiloRead_ID || hif.mdStart_ID));
        m_go    = hif.mdStart_ID && !m_lu && !m_busy;
        m_fa = fwd_ref(hif.rs_EXE, hif.regWriteAddress_EXEtoMEM, hif.regShouldWrite_EXEtoMEM, 1'b1,
                       hif.regWriteAddress_MEMtoWB, hif.regShouldWrite_MEMtoWB, 1'b1);
        m_fb = fwd_ref(hif.rt_EXE, hif.regWriteAddress_EXEtoMEM, hif.regShouldWrite_EXEtoMEM,
                       hif.isRtype_EXEtoMEM, hif.regWriteAddress_MEMtoWB,
                       hif.regShouldWrite_MEMtoWB, hif.isRtype_MEMtoWB);
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic adv();
        model_eval();
        @(posedge clk);
        if (rst) begin
            t0 = -1000; tlu = -1000; m_sc = '0; m_mc = '0;
        end else begin
            if (m_go) t0 = n;
            if (m_idle && m_lu) tlu = n;
            if (m_stall && m_sc != '1) m_sc = m_sc + 1;
            if (m_go && m_mc != '1) m_mc = m_mc + 1;
        end
        n++;
        @(negedge clk);
    endtask

    task automatic clr_in();
        hif.rs_ID = '0; hif.rt_ID = '0; hif.usesRt_ID = 1'b0;
        hif.rs_EXE = '0; hif.rt_EXE = '0;
        hif.regWriteAddress_EXEtoMEM = '0; hif.regWriteAddress_MEMtoWB = '0;
        hif.regShouldWrite_EXEtoMEM = 1'b0; hif.regShouldWrite_MEMtoWB = 1'b0;
        hif.isRtype_EXEtoMEM = 1'b0; hif.isRtype_MEMtoWB = 1'b0;
        hif.memRead_IDtoEXE = 1'b0; hif.regWriteAddress_IDtoEXE = '0;
        hif.mdStart_ID = 1'b0; hif.hiloRead_ID = 1'b0;
    endtask

    task automatic test_reset();
        clr_in();
        rst = 1'b1;
        @(negedge clk); adv(); adv();
        rst = 1'b0;
        settle();
        vec++;
        if (ctl() !== 6'b000000) begin
            err++; $display("FAIL reset_ctl got=%b want=000000", ctl());
        end
        vec++;
        if ({hif.fwdA_sel, hif.fwdB_sel} !== 4'b0000) begin
            err++; $display("FAIL reset_fwd got=%b want=0000", {hif.fwdA_sel, hif.fwdB_sel});
        end
`ifdef HAZARD_STATS_EN
        vec++;
        if (hif.stall_count !== 32'd0 || hif.md_count !== 16'd0) begin
            err++; $display("FAIL reset_stats got=%0d/%0d want=0/0", hif.stall_count, hif.md_count);
        end
`endif
        adv();
    endtask

    task automatic test_fwd_a();
        logic [1:0] want [4] = '{2'b01, 2'b01, 2'b10, 2'b00};
        clr_in();
        hif.rs_EXE = 5'd8;
        for (int k = 0; k < 4; k++) begin
            hif.regWriteAddress_EXEtoMEM = 5'd8;
            hif.regShouldWrite_EXEtoMEM  = (k < 2);
            hif.regWriteAddress_MEMtoWB  = 5'd8;
            hif.regShouldWrite_MEMtoWB   = (k == 1 || k == 2);
            settle();
            vec++;
            if (hif.fwdA_sel !== want[k]) begin
                err++; $display("FAIL fwd_a[%0d] got=%b want=%b", k, hif.fwdA_sel, want[k]);
            end
            adv();
        end
    endtask

    task automatic test_fwd_b();
        logic [1:0] want [4] = '{2'b00, 2'b10, 2'b00, 2'b01};
        logic [4:0] addr [4] = '{5'd9, 5'd9, 5'd0, 5'd9};
        clr_in();
        for (int k = 0; k < 4; k++) begin
            hif.rt_EXE = addr[k];
            hif.regWriteAddress_MEMtoWB  = addr[k];
            hif.regShouldWrite_MEMtoWB   = 1'b1;
            hif.isRtype_MEMtoWB          = (k != 0);
            hif.regWriteAddress_EXEtoMEM = addr[k];
            hif.regShouldWrite_EXEtoMEM  = (k >= 2);
            hif.isRtype_EXEtoMEM         = (k >= 2);
            settle();
            vec++;
            if (hif.fwdB_sel !== want[k]) begin
                err++; $display("FAIL fwd_b[%0d] got=%b want=%b", k, hif.fwdB_sel, want[k]);
            end
            adv();
        end
    endtask

    task automatic test_load_use();
        logic [5:0] want [5] = '{6'b111000, 6'b000000, 6'b000000, 6'b111000, 6'b000000};
        logic       mr   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        clr_in();
        for (int k = 0; k < 5; k++) begin
            hif.memRead_IDtoEXE         = mr[k];
            hif.regWriteAddress_IDtoEXE = (k < 2) ? 5'd5 : 5'd7;
            hif.rs_ID                   = (k < 2) ? 5'd5 : 5'd1;
            hif.rt_ID                   = 5'd7;
            hif.usesRt_ID               = (k >= 3);
            settle();
            vec++;
            if (ctl() !== want[k]) begin
                err++; $display("FAIL load_use[%0d] got=%b want=%b", k, ctl(), want[k]);
            end
            adv();
        end
    endtask

    task automatic test_muldiv();
        logic [5:0] want [6] = '{6'b000100, 6'b111010, 6'b111010, 6'b111010, 6'b111011, 6'b000000};
        clr_in();
        for (int k = 0; k < 6; k++) begin
            hif.mdStart_ID  = (k == 0);
            hif.hiloRead_ID = (k >= 1);
            settle();
            vec++;
            if (ctl() !== want[k]) begin
                err++; $display("FAIL muldiv[t+%0d] got=%b want=%b", k, ctl(), want[k]);
            end
            adv();
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] want [11] = '{6'b000100, 6'b111010, 6'b111010, 6'b111010, 6'b111011,
                                  6'b000100, 6'b000010, 6'b000010, 6'b000010, 6'b000011,
                                  6'b000000};
        clr_in();
        for (int k = 0; k < 11; k++) begin
            hif.mdStart_ID = (k <= 5);
            settle();
            vec++;
            if (ctl() !== want[k]) begin
                err++; $display("FAIL back_to_back[%0d] got=%b want=%b", k, ctl(), want[k]);
            end
            adv();
        end
    endtask

    task automatic test_collision();
        logic [5:0] want [7] = '{6'b111000, 6'b000100, 6'b000010, 6'b000010, 6'b000010,
                                 6'b000011, 6'b000000};
        clr_in();
        for (int k = 0; k < 7; k++) begin
            hif.memRead_IDtoEXE         = (k == 0);
            hif.regWriteAddress_IDtoEXE = 5'd5;
            hif.rs_ID                   = 5'd5;
            hif.mdStart_ID              = (k <= 1);
            settle();
            vec++;
            if (ctl() !== want[k]) begin
                err++; $display("FAIL collision[%0d] got=%b want=%b", k, ctl(), want[k]);
            end
            adv();
        end
    endtask

    task automatic test_reset_mid_op();
        clr_in();
        hif.mdStart_ID = 1'b1;
        settle(); adv();
        hif.mdStart_ID = 1'b0;
        hif.hiloRead_ID = 1'b1;
        settle();
        vec++;
        if (ctl() !== 6'b111010) begin
            err++; $display("FAIL rst_mid_busy got=%b want=111010", ctl());
        end
        adv();
        rst = 1'b1;
        adv();
        rst = 1'b0;
        clr_in();
        for (int k = 0; k < 6; k++) begin
            settle();
            vec++;
            if (ctl() !== 6'b000000) begin
                err++; $display("FAIL rst_mid_after[%0d] got=%b want=000000", k, ctl());
            end
`ifdef HAZARD_STATS_EN
            if (k == 0) begin
                vec++;
                if (hif.stall_count !== 32'd0) begin
                    err++; $display("FAIL rst_mid_stats got=%0d want=0", hif.stall_count);
                end
            end
`endif
            adv();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(299) == 0);
            hif.rs_ID  = 5'($urandom_range(3)); hif.rt_ID  = 5'($urandom_range(3));
            hif.usesRt_ID = 1'($urandom);
            hif.rs_EXE = 5'($urandom_range(3)); hif.rt_EXE = 5'($urandom_range(3));
            hif.regWriteAddress_EXEtoMEM = 5'($urandom_range(3));
            hif.regWriteAddress_MEMtoWB  = 5'($urandom_range(3));
            hif.regShouldWrite_EXEtoMEM  = 1'($urandom);
            hif.regShouldWrite_MEMtoWB   = 1'($urandom);
            hif.isRtype_EXEtoMEM = 1'($urandom); hif.isRtype_MEMtoWB = 1'($urandom);
            hif.memRead_IDtoEXE  = ($urandom_range(2) == 0);
            hif.regWriteAddress_IDtoEXE = 5'($urandom_range(3));
            hif.mdStart_ID  = ($urandom_range(5) == 0);
            hif.hiloRead_ID = ($urandom_range(3) == 0);
            settle();
            vec++;
            if ({hif.fwdA_sel, hif.fwdB_sel} !== {m_fa, m_fb}) begin
                err++; $display("FAIL rand_fwd[%0d] got=%b want=%b", i,
                                {hif.fwdA_sel, hif.fwdB_sel}, {m_fa, m_fb});
            end
            if (!rst) begin
                vec++;
                if (ctl() !== {m_stall, m_stall, m_stall, m_go, m_busy, m_done}) begin
                    err++; $display("FAIL rand_ctl[%0d] got=%b want=%b", i, ctl(),
                                    {m_stall, m_stall, m_stall, m_go, m_busy, m_done});
                end
            end
`ifdef HAZARD_STATS_EN
            vec++;
            if (hif.stall_count !== m_sc || hif.md_count !== m_mc) begin
                err++; $display("FAIL rand_stats[%0d] got=%0d/%0d want=%0d/%0d", i,
                                hif.stall_count, hif.md_count, m_sc, m_mc);
            end
`endif
            adv();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwd_a();
        test_fwd_b();
        test_load_use();
        test_muldiv();
        test_back_to_back();
        test_collision();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
